serial_add_sub: RTL and testbench

Parametrised, digit-serial signed adder/subtractor with a valid/ready handshake on both sides, carry and signed-overflow flags, and optional saturation. It succeeds the combinational 8-bit adder/subtractor in the arithmetic datapath. It trades latency for area: `DIGIT` bits are processed per clock through one narrow adder slice. It sits between an operand producer and a result consumer, either of which may stall.

---
 rtl/serial_add_sub.sv | 148 ++++++++++++++
 tb/tb_serial_add_sub.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// serial_add_sub
// ---------------------------------------------------------------------------
// Digit-serial signed adder/subtractor. One DIGIT-bit adder slice is reused
// for N = WIDTH/DIGIT cycles, so each operation takes N cycles to compute.
// Operands are accepted through a valid/ready handshake. The result is
// presented the same way and is held until the consumer takes it.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst        : synchronous active-high reset, aborts any operation
//   in_valid   : operands and controls are presented
//   in_ready   : block is idle and will take an operation this cycle
//   data0      : signed operand A
//   data1      : signed operand B
//   mode       : 0 = A+B, 1 = A-B
//   sat_en     : clamp the result to the signed range on overflow
//   out_valid  : result and flags are valid
//   out_ready  : consumer accepts the result
//   result     : signed result (wrapped or saturated)
//   carry_out  : raw carry out of the MSB (for subtract, 1 = no borrow)
//   overflow   : signed overflow occurred, reported even when saturated
// ---------------------------------------------------------------------------
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             mode,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_param_check
            $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             sat_reg;
    logic             carry;
    logic [KW-1:0]    k;

    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] clamp;
    logic             ovf_next;
    logic             last;
    int               base;

    assign in_ready = (state == IDLE);
    assign last     = (k == KW'(N - 1));

    // One digit of the addition. b_reg already holds ~B for subtraction and
    // the carry was preset to 1, so the same slice serves both modes.
    // sum_next is the partial sum with the current digit merged in; on the
    // final digit it is the complete wrapped sum, which is what the overflow
    // test and the clamp selection look at.
    always_comb begin
        base     = int'(k) * DIGIT;
        slice    = {1'b0, a_reg[base +: DIGIT]}
                 + {1'b0, b_reg[base +: DIGIT]}
                 + {{DIGIT{1'b0}}, carry};
        sum_next = sum_reg;
        sum_next[base +: DIGIT] = slice[DIGIT-1:0];
        ovf_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                && (sum_next[WIDTH-1] != a_reg[WIDTH-1]);
        clamp    = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
    end

    // Control and datapath registers. The partial sum builds up in sum_reg so
    // that the visible result only changes on the edge that leaves CALC, and
    // otherwise keeps the previous operation's value. Saturation and the flags
    // are registered on that same edge, so the outputs are pure registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            sat_reg   <= 1'b0;
            carry     <= 1'b0;
            k         <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= data0;
                        b_reg   <= mode ? ~data1 : data1;
                        sat_reg <= sat_en;
                        carry   <= mode;
                        sum_reg <= '0;
                        k       <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    sum_reg <= sum_next;
                    carry   <= slice[DIGIT];
                    if (last) begin
                        result    <= (sat_reg && ovf_next) ? clamp : sum_next;
                        carry_out <= slice[DIGIT];
                        overflow  <= ovf_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub
// ---------------------------------------------------------------------------
// Bench for serial_add_sub. A WIDTH=8/DIGIT=2 instance runs directed cases
// with hand-computed values, backpressure and a mid-operation reset, then
// random traffic. Two further instances (16/4 and 8/8) run boundary cases and
// random traffic in parallel. Each instance has an arithmetic reference model
// that is compared against the outputs on every falling edge.
// ---------------------------------------------------------------------------
module tb_serial_add_sub;

    int n_checks = 0;
    int n_pass   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        cy;
        logic        ov;
        logic [63:0] res;
    } ref_t;

    // Reference arithmetic: work on true signed integers, detect overflow by
    // range, derive the carry from unsigned magnitudes, then wrap or clamp.
    function automatic ref_t refOp(input longint a, input longint b,
                                   input bit m, input bit s, input int w);
        ref_t   r;
        longint full, half, maxv, minv, sa, sb, exact;
        full  = longint'(1) << w;
        half  = full >> 1;
        maxv  = half - 1;
        minv  = -half;
        sa    = (a >= half) ? a - full : a;
        sb    = (b >= half) ? b - full : b;
        exact = m ? sa - sb : sa + sb;
        r.ov  = (exact > maxv) || (exact < minv);
        r.cy  = m ? (a >= b) : ((a + b) >= full);
        if (s && r.ov) exact = (exact > maxv) ? maxv : minv;
        r.res = 64'(exact & (full - 1));
        return r;
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Main instance, WIDTH=8 DIGIT=2
    // ------------------------------------------------------------------
    localparam int W = 8;
    localparam int D = 2;
    localparam int N = W / D;

    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] data0     = '0;
    logic [W-1:0] data1     = '0;
    logic         mode      = 1'b0;
    logic         sat_en    = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    serial_add_sub #(.WIDTH(W), .DIGIT(D)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .data0(data0), .data1(data1), .mode(mode), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out), .overflow(overflow)
    );

    // Timing model: idle -> busy for N edges after acceptance -> done until
    // the consumer handshake. Result values latch on entering done.
    int   m_phase = 0;
    int   m_cnt   = 0;
    ref_t m_pend  = '0;
    ref_t m_out   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_out   <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_pend  <= refOp(longint'(data0), longint'(data1), mode, sat_en, W);
                    m_cnt   <= 0;
                    m_phase <= 1;
                end
                1: if (m_cnt == N - 1) begin
                    m_phase <= 2;
                    m_out   <= m_pend;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        checkOutput("main in_ready",  longint'(in_ready),  longint'(m_phase == 0));
        checkOutput("main out_valid", longint'(out_valid), longint'(m_phase == 2));
        checkOutput("main result",    longint'(result),    longint'(m_out.res));
        checkOutput("main carry_out", longint'(carry_out), longint'(m_out.cy));
        checkOutput("main overflow",  longint'(overflow),  longint'(m_out.ov));
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic m, input logic s);
        int guard = 0;
        data0    = a;
        data1    = b;
        mode     = m;
        sat_en   = s;
        in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) checkOutput("main accept timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) checkOutput("main result timeout", 0, 1);
    endtask

    task automatic release1();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic m, input logic s,
                         input logic [W-1:0] er, input logic ec, input logic eo,
                         input string name);
        int lat;
        applyStimulus(a, b, m, s);
        waitResult(lat);
        checkOutput({name, " latency"},   lat, N);
        checkOutput({name, " result"},    longint'(result),    longint'(er));
        checkOutput({name, " carry_out"}, longint'(carry_out), longint'(ec));
        checkOutput({name, " overflow"},  longint'(overflow),  longint'(eo));
        release1();
        checkOutput({name, " in_ready after handshake"}, longint'(in_ready), 1);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
        logic         s;
        logic [W-1:0] r;
        logic         cy;
        logic         ov;
        string        name;
    } vec_t;

    vec_t vecs[7];

    // ------------------------------------------------------------------
    // Sweep instances: 16/4 and 8/8
    // ------------------------------------------------------------------
    for (genvar c = 0; c < 2; c++) begin : g_sweep
        localparam int SW = (c == 0) ? 16 : 8;
        localparam int SD = (c == 0) ? 4 : 8;
        localparam int SN = SW / SD;
        localparam logic [SW-1:0] SMAX = {1'b0, {(SW-1){1'b1}}};
        localparam logic [SW-1:0] SMIN = {1'b1, {(SW-1){1'b0}}};

        logic          s_rst       = 1'b1;
        logic          s_in_valid  = 1'b0;
        logic          s_in_ready;
        logic [SW-1:0] s_data0     = '0;
        logic [SW-1:0] s_data1     = '0;
        logic          s_mode      = 1'b0;
        logic          s_sat_en    = 1'b0;
        logic          s_out_valid;
        logic          s_out_ready = 1'b0;
        logic [SW-1:0] s_result;
        logic          s_carry_out;
        logic          s_overflow;
        bit            sweep_done  = 1'b0;

        serial_add_sub #(.WIDTH(SW), .DIGIT(SD)) u_sweep (
            .clk(clk), .rst(s_rst),
            .in_valid(s_in_valid), .in_ready(s_in_ready),
            .data0(s_data0), .data1(s_data1), .mode(s_mode), .sat_en(s_sat_en),
            .out_valid(s_out_valid), .out_ready(s_out_ready),
            .result(s_result), .carry_out(s_carry_out), .overflow(s_overflow)
        );

        int   s_phase = 0;
        int   s_cnt   = 0;
        ref_t s_pend  = '0;
        ref_t s_out   = '0;

        always @(posedge clk) begin
            if (s_rst) begin
                s_phase <= 0;
                s_out   <= '0;
            end else begin
                case (s_phase)
                    0: if (s_in_valid) begin
                        s_pend  <= refOp(longint'(s_data0), longint'(s_data1), s_mode, s_sat_en, SW);
                        s_cnt   <= 0;
                        s_phase <= 1;
                    end
                    1: if (s_cnt == SN - 1) begin
                        s_phase <= 2;
                        s_out   <= s_pend;
                    end else begin
                        s_cnt <= s_cnt + 1;
                    end
                    default: if (s_out_ready) s_phase <= 0;
                endcase
            end
        end

        always @(negedge clk) begin
            checkOutput($sformatf("W%0dD%0d in_ready", SW, SD),  longint'(s_in_ready),  longint'(s_phase == 0));
            checkOutput($sformatf("W%0dD%0d out_valid", SW, SD), longint'(s_out_valid), longint'(s_phase == 2));
            checkOutput($sformatf("W%0dD%0d result", SW, SD),    longint'(s_result),    longint'(s_out.res));
            checkOutput($sformatf("W%0dD%0d carry_out", SW, SD), longint'(s_carry_out), longint'(s_out.cy));
            checkOutput($sformatf("W%0dD%0d overflow", SW, SD),  longint'(s_overflow),  longint'(s_out.ov));
        end

        // One operation with random consumer stalls; starts and ends at a
        // falling edge where the block is idle again.
        task automatic doOp(input logic [SW-1:0] a, input logic [SW-1:0] b,
                            input logic m, input logic s);
            int guard = 0;
            s_data0    = a;
            s_data1    = b;
            s_mode     = m;
            s_sat_en   = s;
            s_in_valid = 1'b1;
            while (!s_in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) checkOutput($sformatf("W%0dD%0d accept timeout", SW, SD), 0, 1);
            @(negedge clk);
            s_in_valid = 1'b0;
            s_data0    = SW'($urandom);
            s_data1    = SW'($urandom);
            guard      = 0;
            while (1) begin
                s_out_ready = 1'($urandom_range(0, 1));
                if (s_out_valid && s_out_ready) break;
                if (guard >= 100) begin
                    checkOutput($sformatf("W%0dD%0d result timeout", SW, SD), 0, 1);
                    break;
                end
                @(negedge clk);
                guard++;
            end
            @(negedge clk);
            s_out_ready = 1'b0;
        endtask

        initial begin
            repeat (2) @(negedge clk);
            s_rst = 1'b0;
            doOp(SW'(2), SW'(1), 1'b0, 1'b0);
            doOp(SW'(2), SW'(1), 1'b1, 1'b0);
            doOp(SW'(10), SW'(15), 1'b1, 1'b0);
            doOp(SMAX, SMAX, 1'b0, 1'b0);
            doOp(SMAX, SMAX, 1'b0, 1'b1);
            doOp(SMIN, SW'(1), 1'b1, 1'b0);
            doOp(SMIN, SW'(1), 1'b1, 1'b1);
            doOp(SMIN, SMIN, 1'b0, 1'b1);
            doOp(SW'(0), SMIN, 1'b1, 1'b1);
            for (int i = 0; i < 1000; i++) begin
                doOp(SW'($urandom), SW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            sweep_done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Main directed sequence
    // ------------------------------------------------------------------
    initial begin
        int lat;
        int guard;

        vecs[0] = '{8'd2,   8'd1,   1'b0, 1'b0, 8'h03, 1'b0, 1'b0, "add 2+1"};
        vecs[1] = '{8'd2,   8'd1,   1'b1, 1'b0, 8'h01, 1'b1, 1'b0, "sub 2-1"};
        vecs[2] = '{8'd10,  8'd15,  1'b1, 1'b0, 8'hFB, 1'b0, 1'b0, "sub 10-15"};
        vecs[3] = '{8'd100, 8'd100, 1'b0, 1'b0, 8'hC8, 1'b0, 1'b1, "pos ovf wrap"};
        vecs[4] = '{8'd100, 8'd100, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, "pos ovf sat"};
        vecs[5] = '{8'h80,  8'd1,   1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, "neg ovf wrap"};
        vecs[6] = '{8'h80,  8'd1,   1'b1, 1'b1, 8'h80, 1'b1, 1'b1, "neg ovf sat"};

        repeat (2) @(negedge clk);
        checkOutput("reset in_ready",  longint'(in_ready),  1);
        checkOutput("reset out_valid", longint'(out_valid), 0);
        checkOutput("reset result",    longint'(result),    0);
        checkOutput("reset carry_out", longint'(carry_out), 0);
        checkOutput("reset overflow",  longint'(overflow),  0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            runOp(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].s,
                  vecs[i].r, vecs[i].cy, vecs[i].ov, vecs[i].name);
        end

        // Backpressure with the producer pushing changing operands.
        applyStimulus(8'd5, 8'd3, 1'b0, 1'b0);
        waitResult(lat);
        checkOutput("bp latency", lat, N);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            data0    = W'($urandom);
            data1    = W'($urandom);
            mode     = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput("bp result held",    longint'(result),    8);
            checkOutput("bp in_ready low",   longint'(in_ready),  0);
            checkOutput("bp out_valid held", longint'(out_valid), 1);
        end
        data0     = 8'd7;
        data1     = 8'd9;
        mode      = 1'b0;
        sat_en    = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp in_ready after handshake", longint'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp next accepted", longint'(in_ready), 0);
        waitResult(lat);
        checkOutput("bp next latency", lat, N);
        checkOutput("bp next result", longint'(result), 16);
        release1();

        // Reset while the digit counter sits at 2.
        applyStimulus(8'd50, 8'd20, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset in_ready",  longint'(in_ready),  1);
        checkOutput("midreset out_valid", longint'(out_valid), 0);
        checkOutput("midreset result",    longint'(result),    0);
        runOp(8'd15, 8'd10, 1'b0, 1'b0, 8'd25, 1'b0, 1'b0, "after reset 15+10");

        // Random traffic with consumer stalls; the model checks every cycle.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            guard = 0;
            while (1) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) break;
                if (guard >= 100) begin
                    checkOutput("main random timeout", 0, 1);
                    break;
                end
                @(negedge clk);
                guard++;
            end
            @(negedge clk);
            out_ready = 1'b0;
        end

        guard = 0;
        while (!(g_sweep[0].sweep_done && g_sweep[1].sweep_done) && guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("sweep completion",
                    longint'(g_sweep[0].sweep_done && g_sweep[1].sweep_done), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
